// File: rtl/serial_adder_ctrl_pkg.sv
// serial_adder_defs: shared definitions for the bit-serial adder sequencer.
//   state_e   : FSM state encoding (IDLE / RUN / DONE, 2 bits)
//   DEF_WIDTH : default operand width
package serial_adder_defs;
    localparam int DEF_WIDTH = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;
endpackage

// File: rtl/serial_fa_cell.sv
// serial_fa_cell: combinational 1-bit full adder, the only arithmetic in the
// serial adder.
//   x_i, y_i : operand bits
//   ci_i     : carry in
//   s_o      : x ^ y ^ ci
//   co_o     : majority(x, y, ci)
module serial_fa_cell (
    input  logic x_i,
    input  logic y_i,
    input  logic ci_i,
    output logic s_o,
    output logic co_o
);
    assign s_o  = x_i ^ y_i ^ ci_i;
    assign co_o = (x_i & y_i) | (x_i & ci_i) | (y_i & ci_i);
endmodule

// File: rtl/serial_adder_ctrl.sv
// serial_adder_ctrl: bit-serial add sequencer. One full-adder cell is reused
// over WIDTH cycles to form {c_out, sum} = a + b + c_in.
//   clk, rst            : clock, synchronous active-high reset
//   in_valid/in_ready   : operand handshake (a, b, c_in captured on accept)
//   out_valid/out_ready : result handshake (sum, c_out held while stalled)
//   busy                : high while bits are being processed
//   ovf                 : signed overflow, present only when
//                         SERIAL_ADDER_OVF_EN is defined
module serial_adder_ctrl
    import serial_adder_defs::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             c_out,
    output logic             busy
`ifdef SERIAL_ADDER_OVF_EN
   ,output logic             ovf
`endif
);
    localparam int CW = $clog2(WIDTH);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d, res_q, res_d;
    logic             carry_q, carry_d;
    logic             cout_q, cout_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             fa_s, fa_co;
`ifdef SERIAL_ADDER_OVF_EN
    logic             ovf_q, ovf_d;
`endif

    serial_fa_cell u_fa (
        .x_i  (a_q[0]),
        .y_i  (b_q[0]),
        .ci_i (carry_q),
        .s_o  (fa_s),
        .co_o (fa_co)
    );

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        carry_d = carry_q;
        cout_d  = cout_q;
        cnt_d   = cnt_q;
`ifdef SERIAL_ADDER_OVF_EN
        ovf_d   = ovf_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    a_d     = a;
                    b_d     = b;
                    carry_d = c_in;
                    cnt_d   = '0;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                // LSB first: result fills from the top and is aligned after WIDTH shifts
                res_d   = {fa_s, res_q[WIDTH-1:1]};
                a_d     = a_q >> 1;
                b_d     = b_q >> 1;
                carry_d = fa_co;
                cnt_d   = cnt_q + CW'(1);
                if (cnt_q == CW'(WIDTH - 1)) begin
                    cout_d  = fa_co;
`ifdef SERIAL_ADDER_OVF_EN
                    // carry_q is the carry into the MSB on this edge
                    ovf_d   = fa_co ^ carry_q;
`endif
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                if (out_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            cnt_q   <= '0;
`ifdef SERIAL_ADDER_OVF_EN
            ovf_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
            cnt_q   <= cnt_d;
`ifdef SERIAL_ADDER_OVF_EN
            ovf_q   <= ovf_d;
`endif
        end
    end

    assign in_ready  = (state_q == ST_IDLE);
    assign busy      = (state_q == ST_RUN);
    assign out_valid = (state_q == ST_DONE);
    assign sum       = res_q;
    assign c_out     = cout_q;
`ifdef SERIAL_ADDER_OVF_EN
    assign ovf       = ovf_q;
`endif
endmodule
